// File: rtl/mac_control_unit.sv
// Sequencing core for the MAC: trinomial (a*x+b)*x+c in two passes, or a
// running sum of a*x products, both sharing one 17x8 multiplier and one adder.
module mac_control_unit (
  input  logic        clk,
  input  logic        reset,
  input  logic        valid_input,
  output logic        ready_input,
  input  logic        last_input,
  input  logic        mode,
  input  logic [7:0]  num_a,
  input  logic [7:0]  num_x,
  input  logic [7:0]  num_b,
  input  logic [7:0]  num_c,
  output logic        valid_output,
  output logic [16:0] final_output
);

  typedef enum logic [1:0] {IDLE, TRI_2, SUMP} state_t;

  state_t      state, state_nx;
  logic [16:0] acc;
  logic [7:0]  x_lat, c_lat;
  logic [16:0] mul_a, addend, prod, sum;
  logic [7:0]  mul_x;
  logic        accept, acc_en, lat_en, res_en;

  assign ready_input = (state != TRI_2);
  assign accept      = valid_input && ready_input;

  // Product and sum are only ever needed mod 2^17, so the shared stage is 17 bits wide.
  assign prod = mul_a * {9'd0, mul_x};
  assign sum  = prod + addend;

  always_comb begin
    state_nx = state;
    mul_a    = {9'd0, num_a};
    mul_x    = num_x;
    addend   = '0;
    acc_en   = 1'b0;
    lat_en   = 1'b0;
    res_en   = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          if (mode) begin
            addend   = {9'd0, num_b};
            acc_en   = 1'b1;
            lat_en   = 1'b1;
            state_nx = TRI_2;
          end else if (last_input) begin
            res_en   = 1'b1;
          end else begin
            acc_en   = 1'b1;
            state_nx = SUMP;
          end
        end
      end
      TRI_2: begin
        // Second pass reuses the multiplier with the partial result as the wide operand.
        mul_a    = acc;
        mul_x    = x_lat;
        addend   = {9'd0, c_lat};
        res_en   = 1'b1;
        state_nx = IDLE;
      end
      SUMP: begin
        addend = acc;
        if (accept) begin
          if (last_input) begin
            res_en   = 1'b1;
            state_nx = IDLE;
          end else begin
            acc_en   = 1'b1;
          end
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nx;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      acc          <= '0;
      x_lat        <= '0;
      c_lat        <= '0;
      final_output <= '0;
      valid_output <= 1'b0;
    end else begin
      valid_output <= res_en;
      if (acc_en) acc          <= sum;
      if (res_en) final_output <= sum;
      if (lat_en) begin
        x_lat <= num_x;
        c_lat <= num_c;
      end
    end
  end

endmodule

// File: tb/tb_mac_control_unit.sv
// Bench for mac_control_unit: vector table with latency checks, hand-written
// back-to-back/reset sequences, and randomized operations against an arithmetic model.
module tb_mac_control_unit;

  logic        clk = 1'b0, reset = 1'b0;
  logic        valid_input = 1'b0, last_input = 1'b0, mode = 1'b0;
  logic [7:0]  num_a = '0, num_x = '0, num_b = '0, num_c = '0;
  logic        ready_input, valid_output;
  logic [16:0] final_output;

  mac_control_unit dut (
    .clk(clk), .reset(reset), .valid_input(valid_input), .ready_input(ready_input),
    .last_input(last_input), .mode(mode), .num_a(num_a), .num_x(num_x),
    .num_b(num_b), .num_c(num_c), .valid_output(valid_output), .final_output(final_output)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int obs_val[$], obs_cyc[$];
  always @(negedge clk)
    if (valid_output === 1'b1) begin
      obs_val.push_back(int'(final_output));
      obs_cyc.push_back(cyc);
    end

  int n_chk = 0, n_fail = 0;

  task automatic chk(input string nm, input int got, input int exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", nm, got, exp);
    end
  endtask

  // Present a beat from the next falling edge; returns the cycle index of the accepting edge.
  task automatic beat(input logic m, input logic l, input logic [7:0] a, x, b, c,
                      output int acc);
    acc = -1;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      valid_input = 1'b1; mode = m; last_input = l;
      num_a = a; num_x = x; num_b = b; num_c = c;
      if (ready_input === 1'b1) begin
        acc = cyc;
        @(posedge clk);
        break;
      end
    end
    if (acc < 0) begin
      n_chk++; n_fail++;
      $display("FAIL accept_timeout: beat not accepted within 20 cycles");
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      valid_input = 1'b0;
    end
  endtask

  task automatic expect_res(input string nm, input int expv, input int expc);
    int k = 0;
    while (obs_val.size() == 0 && k < 10) begin
      @(posedge clk);
      k++;
    end
    if (obs_val.size() == 0) begin
      n_chk++; n_fail++;
      $display("FAIL %s timeout: no strobe, expected value %0d", nm, expv);
    end else begin
      chk({nm, " value"}, obs_val.pop_front(), expv);
      chk({nm, " latency"}, obs_cyc.pop_front(), expc);
    end
  endtask

  task automatic no_extra(input string nm);
    repeat (3) @(posedge clk);
    chk({nm, " extra strobes"}, obs_val.size(), 0);
    obs_val.delete();
    obs_cyc.delete();
  endtask

  typedef struct {
    string          name;
    logic           mode;
    int             n;
    logic [2:0][7:0] a;
    logic [2:0][7:0] x;
    logic [7:0]     b, c;
    int             exp;
  } vec_t;

  function automatic vec_t mkv(input string nm, input logic m, input int n,
      input int a0, x0, a1, x1, a2, x2, b, c, e);
    vec_t v;
    v.name = nm; v.mode = m; v.n = n;
    v.a[0] = 8'(a0); v.x[0] = 8'(x0);
    v.a[1] = 8'(a1); v.x[1] = 8'(x1);
    v.a[2] = 8'(a2); v.x[2] = 8'(x2);
    v.b = 8'(b); v.c = 8'(c); v.exp = e;
    return v;
  endfunction

  vec_t vecs[6];
  int   exp_q[$];

  initial begin
    int a1, a2, ac;
    vecs[0] = mkv("tri_5_3_2_1",   1'b1, 1,   5,   3,   0,   0,   0,   0,   2,   1,    52);
    vecs[1] = mkv("tri_255_all",   1'b1, 1, 255, 255,   0,   0,   0,   0, 255, 255,   511);
    vecs[2] = mkv("tri_a0",        1'b1, 1,   0, 200,   0,   0,   0,   0,   3,   7,   607);
    vecs[3] = mkv("sop_2beat",     1'b0, 2,   5,   3,   9,   8,   0,   0,   0,   0,    87);
    vecs[4] = mkv("sop_3x255",     1'b0, 3, 255, 255, 255, 255, 255, 255,   0,   0, 64003);
    vecs[5] = mkv("sop_single",    1'b0, 1,   4,   4,   0,   0,   0,   0,   0,   0,    16);

    repeat (3) @(posedge clk);
    #1;
    chk("reset valid_output", int'(valid_output), 0);
    chk("reset final_output", int'(final_output), 0);
    @(negedge clk) reset = 1'b1;
    #1 chk("ready after reset", int'(ready_input), 1);

    for (int i = 0; i < 6; i++) begin
      if (vecs[i].mode) begin
        beat(1'b1, 1'b0, vecs[i].a[0], vecs[i].x[0], vecs[i].b, vecs[i].c, ac);
        @(negedge clk);
        valid_input = 1'b0;
        chk({vecs[i].name, " ready low"}, int'(ready_input), 0);
        expect_res(vecs[i].name, vecs[i].exp, ac + 2);
      end else begin
        for (int j = 0; j < vecs[i].n; j++)
          beat(1'b0, j == vecs[i].n - 1, vecs[i].a[j], vecs[i].x[j], 8'hA5, 8'h5A, ac);
        idle(1);
        expect_res(vecs[i].name, vecs[i].exp, ac + 1);
      end
      no_extra(vecs[i].name);
    end

    // Second trinomial held on the inputs through TRI_2; taken only when ready returns.
    beat(1'b1, 1'b0, 8'd5, 8'd3, 8'd2, 8'd1, a1);
    beat(1'b1, 1'b0, 8'd9, 8'd8, 8'd7, 8'd6, a2);
    chk("b2b accept spacing", a2 - a1, 2);
    idle(1);
    expect_res("b2b tri1", 52, a1 + 2);
    expect_res("b2b tri2", 638, a2 + 2);
    no_extra("b2b");

    // Reset mid-sum: the partial sum must vanish without a strobe.
    beat(1'b0, 1'b0, 8'd10, 8'd10, 8'd0, 8'd0, ac);
    beat(1'b0, 1'b0, 8'd3, 8'd3, 8'd0, 8'd0, ac);
    @(negedge clk);
    valid_input = 1'b0;
    reset = 1'b0;
    #1;
    chk("midreset valid_output", int'(valid_output), 0);
    chk("midreset final_output", int'(final_output), 0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    chk("midreset no strobe", obs_val.size(), 0);
    beat(1'b0, 1'b1, 8'd4, 8'd4, 8'd0, 8'd0, ac);
    idle(1);
    expect_res("after reset single", 16, ac + 1);
    no_extra("after reset");

    // Randomized operations; model works directly from the functions' definitions.
    for (int op = 0; op < 200; op++) begin
      int a, x, b, c, n, s;
      if ($urandom_range(0, 1) == 1) begin
        a = $urandom_range(0, 255); x = $urandom_range(0, 255);
        b = $urandom_range(0, 255); c = $urandom_range(0, 255);
        exp_q.push_back(((a * x + b) * x + c) % 131072);
        beat(1'b1, 1'($urandom_range(0, 1)), 8'(a), 8'(x), 8'(b), 8'(c), ac);
      end else begin
        n = $urandom_range(1, 4);
        s = 0;
        for (int j = 0; j < n; j++) begin
          a = $urandom_range(0, 255); x = $urandom_range(0, 255);
          s = (s + a * x) % 131072;
          beat(j == 0 ? 1'b0 : 1'($urandom_range(0, 1)), j == n - 1, 8'(a), 8'(x),
               8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), ac);
        end
        exp_q.push_back(s);
      end
      if ($urandom_range(0, 3) == 0) idle(1);
    end
    idle(1);
    repeat (5) @(posedge clk);
    chk("random result count", obs_val.size(), exp_q.size());
    while (obs_val.size() > 0 && exp_q.size() > 0)
      chk("random result", obs_val.pop_front(), exp_q.pop_front());

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

endmodule
